// File: rtl/kcell_pkg.sv
// Shared types and constants for the kernel-cell feeder.
// Drain length depends on whether lane skew (KCELL_FEEDER_SKEW_EN) is built in.
package kcell_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DIMX       = 3;
    localparam int DEF_DIMY       = 3;
    localparam int DEF_LEN_WIDTH  = 16;

    // Zero cycles needed after the last beat so every kernel column flushes;
    // skewed lanes add DIMY-1 more so the deepest lane also empties.
    function automatic int drain_cycles(input int dimx, input int dimy, input bit skew);
        return skew ? (dimx + dimy - 1) : dimx;
    endfunction

endpackage

// File: rtl/kcell_feeder_lane_skew.sv
// Zero-reset delay line for one activation lane; used only when
// KCELL_FEEDER_SKEW_EN is defined. DEPTH must be at least 1.
module lane_skew #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/kcell_feeder.sv
// Feeds a DIMX x DIMY kernel: loads cell weights, then streams activation columns
// followed by a zero drain. Define KCELL_FEEDER_SKEW_EN to stagger lane r by r cycles.
module kcell_feeder
    import kcell_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIMX       = DEF_DIMX,
    parameter int DIMY       = DEF_DIMY,
    parameter int NUM_CELLS  = DIMX * DIMY,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           cfg_len,
    input  logic                           wgt_in_valid,
    output logic                           wgt_in_ready,
    input  logic [DATA_WIDTH-1:0]          wgt_in,
    input  logic                           act_in_valid,
    output logic                           act_in_ready,
    input  logic [DIMY*DATA_WIDTH-1:0]     act_in,
    output logic [NUM_CELLS*DATA_WIDTH-1:0] wgt_data,
    output logic [NUM_CELLS-1:0]           wgt_load_gbl,
    output logic [DIMY*DATA_WIDTH-1:0]     act_data,
    output logic                           act_valid,
    output logic                           busy,
    output logic                           done
);

`ifdef KCELL_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    localparam int DRAIN_CYC = drain_cycles(DIMX, DIMY, SKEW);
    localparam int CW        = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    state_t                      state, state_nxt;
    logic [LEN_WIDTH-1:0]        len_q;
    logic [LEN_WIDTH-1:0]        beat_cnt;
    logic [CW-1:0]               wgt_cnt;
    logic [DCW-1:0]              drain_cnt;
    logic [DIMY*DATA_WIDTH-1:0]  act_reg;
    logic                        act_vld_q;

    logic wgt_hs, act_hs, wgt_last, beat_last, drain_last;

    assign wgt_hs     = wgt_in_ready && wgt_in_valid;
    assign act_hs     = act_in_ready && act_in_valid;
    assign wgt_last   = (wgt_cnt == CW'(NUM_CELLS - 1));
    // len_q is never zero in STREAM, so len_q-1 cannot underflow and the count never wraps
    assign beat_last  = (beat_cnt == len_q - LEN_WIDTH'(1));
    assign drain_last = (state == DRAIN) && (drain_cnt == DCW'(DRAIN_CYC - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        wgt_in_ready = 1'b0;
        act_in_ready = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                wgt_in_ready = 1'b1;
                if (wgt_hs && wgt_last)
                    state_nxt = (len_q == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                act_in_ready = 1'b1;
                if (act_hs && beat_last) state_nxt = DRAIN;
            end
            DRAIN: if (drain_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q        <= '0;
            beat_cnt     <= '0;
            wgt_cnt      <= '0;
            drain_cnt    <= '0;
            wgt_data     <= '0;
            wgt_load_gbl <= '0;
            act_reg      <= '0;
            act_vld_q    <= 1'b0;
            done         <= 1'b0;
        end else begin
            wgt_load_gbl <= '0;
            act_reg      <= '0;
            act_vld_q    <= 1'b0;
            done         <= drain_last;

            if (state == IDLE && start) begin
                len_q     <= cfg_len;
                beat_cnt  <= '0;
                wgt_cnt   <= '0;
                drain_cnt <= '0;
            end

            if (wgt_hs) begin
                wgt_data[(NUM_CELLS-1-int'(wgt_cnt))*DATA_WIDTH +: DATA_WIDTH] <= wgt_in;
                wgt_load_gbl[wgt_cnt] <= 1'b1;
                wgt_cnt               <= wgt_cnt + CW'(1);
            end

            if (act_hs) begin
                act_reg   <= act_in;
                act_vld_q <= 1'b1;
                beat_cnt  <= beat_last ? '0 : beat_cnt + LEN_WIDTH'(1);
            end

            if (state == DRAIN)
                drain_cnt <= drain_last ? '0 : drain_cnt + DCW'(1);
        end
    end

`ifdef KCELL_FEEDER_SKEW_EN
    assign act_data[DIMY*DATA_WIDTH-1 -: DATA_WIDTH] = act_reg[DIMY*DATA_WIDTH-1 -: DATA_WIDTH];
    for (genvar r = 1; r < DIMY; r++) begin : g_skew
        lane_skew #(.W(DATA_WIDTH), .DEPTH(r)) u_skew (
            .clk  (clk),
            .reset(reset),
            .din  (act_reg[(DIMY-r)*DATA_WIDTH-1 -: DATA_WIDTH]),
            .dout (act_data[(DIMY-r)*DATA_WIDTH-1 -: DATA_WIDTH])
        );
    end
`else
    assign act_data = act_reg;
`endif
    assign act_valid = act_vld_q;

endmodule

// File: tb/tb_kcell_feeder.sv
// Scoreboard bench for kcell_feeder: drivers schedule expected outputs by cycle,
// a negedge monitor compares every cycle. Honours KCELL_FEEDER_SKEW_EN.
module tb_kcell_feeder;

    localparam int DW   = 8;
    localparam int DIMX = 3;
    localparam int DIMY = 3;
    localparam int NC   = DIMX * DIMY;
    localparam int LW   = 16;
`ifdef KCELL_FEEDER_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif
    localparam int DRAIN = SKEW ? (DIMX + DIMY - 1) : DIMX;
    localparam int FAR   = 32'h7fff_ffff;

    logic                 clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [LW-1:0]        cfg_len = '0;
    logic                 wgt_in_valid = 1'b0, act_in_valid = 1'b0;
    logic [DW-1:0]        wgt_in = '0;
    logic [DIMY*DW-1:0]   act_in = '0;
    logic                 wgt_in_ready, act_in_ready, act_valid, busy, done;
    logic [NC*DW-1:0]     wgt_data;
    logic [NC-1:0]        wgt_load_gbl;
    logic [DIMY*DW-1:0]   act_data;

    kcell_feeder #(.DATA_WIDTH(DW), .DIMX(DIMX), .DIMY(DIMY), .NUM_CELLS(NC), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .wgt_in_valid(wgt_in_valid), .wgt_in_ready(wgt_in_ready), .wgt_in(wgt_in),
        .act_in_valid(act_in_valid), .act_in_ready(act_in_ready), .act_in(act_in),
        .wgt_data(wgt_data), .wgt_load_gbl(wgt_load_gbl),
        .act_data(act_data), .act_valid(act_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: what should appear in which cycle
    int            exp_load [int];
    logic [DW-1:0] exp_lane [int];
    bit            exp_vld  [int];
    int            exp_done [$];
    logic [DW-1:0] model_w  [NC];
    int            busy_from = FAR, busy_until = FAR, cur_len = 0;
    int            errors = 0, checks = 0;

    logic [DW-1:0]      wq [NC];
    logic [DIMY*DW-1:0] aq [$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic flush();
        exp_load.delete(); exp_lane.delete(); exp_vld.delete(); exp_done.delete();
        for (int k = 0; k < NC; k++) model_w[k] = '0;
        busy_from = FAR; busy_until = FAR;
    endtask

    always @(negedge clk) begin : mon
        logic [NC*DW-1:0] wimg;
        logic [NC-1:0]    lexp;
        bit               bexp;
        for (int k = 0; k < NC; k++) wimg[(NC-1-k)*DW +: DW] = model_w[k];
        lexp = '0;
        if (exp_load.exists(cyc)) begin
            lexp[exp_load[cyc]] = 1'b1;
            exp_load.delete(cyc);
        end
        chk("wgt_load_gbl", wgt_load_gbl, lexp);
        chk("wgt_data", wgt_data, wimg);
        for (int r = 0; r < DIMY; r++) begin
            logic [DW-1:0] le;
            le = '0;
            if (exp_lane.exists(cyc*4 + r)) begin
                le = exp_lane[cyc*4 + r];
                exp_lane.delete(cyc*4 + r);
            end
            chk("act_lane", act_data[(DIMY-1-r)*DW +: DW], le);
        end
        chk("act_valid", act_valid, exp_vld.exists(cyc));
        if (exp_vld.exists(cyc)) exp_vld.delete(cyc);
        bexp = (cyc >= busy_from) && (cyc < busy_until);
        chk("busy", busy, bexp);
        if (!bexp) chk("ready_idle", {wgt_in_ready, act_in_ready}, 2'b00);
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else                      chk("done_cycle", cyc, exp_done.pop_front());
        end
    end

    task automatic push_done(input int c);
        exp_done.push_back(c + DRAIN);
        busy_until = c + DRAIN;
    endtask

    task automatic start_job(input int len);
        @(negedge clk);
        start = 1'b1; cfg_len = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        busy_from = cyc; busy_until = FAR; cur_len = len;
    endtask

    task automatic load_weights(input int n, input bit gaps);
        int k = 0, budget = 0;
        bit hs;
        while (k < n && budget < 400) begin
            @(negedge clk);
            budget++;
            wgt_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            wgt_in = wq[k];
            if (budget == 1 || wgt_in_ready !== 1'b1 || act_in_ready !== 1'b0)
                chk("load_ready", {wgt_in_ready, act_in_ready}, 2'b10);
            hs = wgt_in_valid;
            @(posedge clk); #1;
            if (hs) begin
                exp_load[cyc] = k;
                model_w[k] = wq[k];
                if (k == NC-1 && cur_len == 0) push_done(cyc);
                k++;
            end
        end
        wgt_in_valid = 1'b0;
        if (k < n) chk("load_timeout", k, n);
    endtask

    // mode 0: no stalls, 1: stall every other cycle, 2: random stalls
    task automatic stream(input int mode, input bit inject);
        int b = 0, budget = 0, n;
        bit hs;
        n = aq.size();
        while (b < n && budget < 200000) begin
            @(negedge clk);
            budget++;
            case (mode)
                0:       act_in_valid = 1'b1;
                1:       act_in_valid = budget[0];
                default: act_in_valid = ($urandom_range(0, 2) != 0);
            endcase
            act_in = aq[b];
            if (inject && b == 1) start = 1'b1;
            if (budget == 1 || act_in_ready !== 1'b1 || wgt_in_ready !== 1'b0)
                chk("stream_ready", {wgt_in_ready, act_in_ready}, 2'b01);
            hs = act_in_valid;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) begin
                exp_vld[cyc] = 1'b1;
                for (int r = 0; r < DIMY; r++)
                    exp_lane[(cyc + r*SKEW)*4 + r] = aq[b][(DIMY-1-r)*DW +: DW];
                if (b == n-1) push_done(cyc);
                b++;
            end
        end
        act_in_valid = 1'b0;
        if (b < n) chk("stream_timeout", b, n);
    endtask

    task automatic wait_done();
        int budget = 0;
        bit quiet = 1'b1;
        while (exp_done.size() > 0 && budget < 100) begin
            @(posedge clk); #2;
            budget++;
            if (wgt_in_ready !== 1'b0 || act_in_ready !== 1'b0) quiet = 1'b0;
        end
        chk("drain_ready_low", quiet, 1'b1);
        if (exp_done.size() > 0) begin
            chk("done_timeout", exp_done.size(), 0);
            exp_done.delete();
            busy_from = FAR;
        end
        @(negedge clk);
    endtask

    task automatic rand_job(input int len, input int mode, input bit gaps, input bit inject);
        for (int k = 0; k < NC; k++) wq[k] = DW'($urandom);
        aq.delete();
        for (int i = 0; i < len; i++) aq.push_back((DIMY*DW)'($urandom));
        start_job(len);
        load_weights(NC, gaps);
        if (len > 0) stream(mode, inject);
        wait_done();
    endtask

    initial begin
        flush();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {wgt_data, wgt_load_gbl, act_data, act_valid, busy, done, wgt_in_ready, act_in_ready}, '0);
        reset = 1'b1;

        // directed job: weights 1..9, four beats with stalls
        for (int k = 0; k < NC; k++) wq[k] = DW'(k + 1);
        aq.delete();
        aq.push_back(24'h0A0B0C); aq.push_back(24'h0D0E0F);
        aq.push_back(24'h101112); aq.push_back(24'h131415);
        start_job(4);
        load_weights(NC, 1'b0);
        stream(1, 1'b0);
        wait_done();
        chk("wgt_data_final", wgt_data, 72'h010203040506070809);

        // empty activation job
        rand_job(0, 0, 1'b0, 1'b0);

        // start pulsed mid-stream must be ignored
        rand_job(5, 2, 1'b0, 1'b1);

        // reset after the fifth weight, valid held across release
        for (int k = 0; k < NC; k++) wq[k] = DW'($urandom);
        start_job(3);
        load_weights(5, 1'b0);
        reset = 1'b0;
        flush();
        @(negedge clk);
        chk("midjob_reset", {wgt_data, wgt_load_gbl, act_data, act_valid, busy, done, wgt_in_ready, act_in_ready}, '0);
        wgt_in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        wgt_in_valid = 1'b0;
        rand_job(3, 2, 1'b1, 1'b0);

        // single beat (lane skew visible when enabled)
        for (int k = 0; k < NC; k++) wq[k] = DW'($urandom);
        aq.delete(); aq.push_back(24'h010203);
        start_job(1);
        load_weights(NC, 1'b0);
        stream(0, 1'b0);
        wait_done();

        for (int j = 0; j < 4; j++) rand_job($urandom_range(1, 6), 2, 1'b1, 1'b0);

        // maximum beat count, no stalls
        rand_job(65535, 0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
